// File: rtl/nandn_filt_brick.sv
// Parametrised masked N-input NAND with per-input synchroniser and a clocked deglitch
// filter; reports an output-change pulse and a saturating count of rejected glitches.
module nandn_filt_brick #(
  parameter int unsigned N_IN        = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4,
  parameter logic        RST_VAL     = 1'b1,
  parameter int unsigned GCW         = 8
) (
  input  logic            CELCLK,
  input  logic            CELRST,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            SUB,
  input  logic [N_IN-1:0] i,
  input  logic [N_IN-1:0] mask,
  output logic            o,
  output logic            o_chg,
  output logic [GCW-1:0]  glitch_cnt
);

  localparam int unsigned CW = (FILT_CYC < 1) ? 1 : $clog2(FILT_CYC + 1);

  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } state_t;

  logic [N_IN-1:0] s;
  logic            raw;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            o_n, o_chg_n;
  logic [GCW-1:0]  glitch_cnt_n;

  // Power/substrate pins carried for netlist connectivity only.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  // Input synchroniser; zero stages means inputs are already in the CELCLK domain.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = i;
  end else begin : g_sync
    logic [N_IN-1:0] ff [SYNC_STAGES];

    always_ff @(posedge CELCLK or posedge CELRST) begin
      if (CELRST) begin
        for (int unsigned k = 0; k < SYNC_STAGES; k++) ff[k] <= '0;
      end else begin
        ff[0] <= i;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) ff[k] <= ff[k-1];
      end
    end

    assign s = ff[SYNC_STAGES-1];
  end

  // Masked inputs are forced high, so an all-masked brick reads raw=0.
  assign raw = ~&(s | mask);

  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      state      <= STABLE;
      cnt        <= '0;
      o          <= RST_VAL;
      o_chg      <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      o          <= o_n;
      o_chg      <= o_chg_n;
      glitch_cnt <= glitch_cnt_n;
    end
  end

  // Deglitch filter: raw must differ from o for FILT_CYC+1 sampled edges to commit.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    o_n          = o;
    o_chg_n      = 1'b0;
    glitch_cnt_n = glitch_cnt;

    case (state)
      STABLE: begin
        if (raw != o) begin
          if (FILT_CYC == 0) begin
            o_n     = raw;
            o_chg_n = 1'b1;
          end else begin
            state_n = PEND;
            cnt_n   = CW'(1);
          end
        end
      end

      PEND: begin
        if (raw == o) begin
          state_n = STABLE;
          cnt_n   = '0;
          if (glitch_cnt != '1) glitch_cnt_n = glitch_cnt + GCW'(1);
        end else if (cnt == CW'(FILT_CYC)) begin
          o_n     = raw;
          o_chg_n = 1'b1;
          state_n = STABLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n = STABLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
